// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: dm_ctrl codes, FSM states
// and the access legality check used at request acceptance.
package dmem_bridge_pkg;

   localparam logic [2:0] dm_word              = 3'b000;
   localparam logic [2:0] dm_halfword          = 3'b001;
   localparam logic [2:0] dm_halfword_unsigned = 3'b010;
   localparam logic [2:0] dm_byte              = 3'b011;
   localparam logic [2:0] dm_byte_unsigned     = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Misaligned halves/words and the unused codes 101..111 never reach memory.
   function automatic logic access_error(input logic [1:0] offset, input logic [2:0] ctrl);
      case (ctrl)
         dm_word:                           return offset != 2'b00;
         dm_halfword, dm_halfword_unsigned: return offset[0];
         dm_byte, dm_byte_unsigned:         return 1'b0;
         default:                           return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// Bus bundles around the bridge: the core-facing request channel and the
// word-organised memory channel.
interface dmem_cpu_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [2:0]  cpu_dm_ctrl;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        cpu_err;

   modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dm_ctrl,
                   input  cpu_rdata, cpu_ready, cpu_err);
   modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dm_ctrl,
                   output cpu_rdata, cpu_ready, cpu_err);
endinterface

interface dmem_mem_if #(parameter int ADDR_W = 10);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   input  mem_rdata, mem_ack);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   output mem_rdata, mem_ack);
endinterface

// File: rtl/dmem_bridge_lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load
// extraction with sign or zero extension.
module dmem_lane_align
   import dmem_bridge_pkg::*;
(
   input  logic [1:0]  i_offset,
   input  logic [2:0]  i_dm_ctrl,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_load_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_store_word,
   output logic [31:0] o_load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte       = i_load_word[{i_offset, 3'b000} +: 8];
      w_half       = i_offset[1] ? i_load_word[31:16] : i_load_word[15:0];
      o_be         = 4'b1111;
      o_store_word = i_store_data;
      o_load_data  = i_load_word;
      case (i_dm_ctrl)
         dm_halfword: begin
            o_be         = i_offset[1] ? 4'b1100 : 4'b0011;
            o_store_word = {2{i_store_data[15:0]}};
            o_load_data  = {{16{w_half[15]}}, w_half};
         end
         dm_halfword_unsigned: begin
            o_be         = i_offset[1] ? 4'b1100 : 4'b0011;
            o_store_word = {2{i_store_data[15:0]}};
            o_load_data  = {16'h0000, w_half};
         end
         dm_byte: begin
            o_be         = 4'b0001 << i_offset;
            o_store_word = {4{i_store_data[7:0]}};
            o_load_data  = {{24{w_byte[7]}}, w_byte};
         end
         dm_byte_unsigned: begin
            o_be         = 4'b0001 << i_offset;
            o_store_word = {4{i_store_data[7:0]}};
            o_load_data  = {24'h000000, w_byte};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_bridge.sv
// Data-side access unit between the single-cycle core and a word RAM:
// req/ack handshake with watchdog, one-cycle completion pulse to MIO_ready.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int TIMEOUT = 15
)(
   input logic          clk,
   input logic          reset,
   dmem_cpu_if.slave    cpu,
   dmem_mem_if.master   mem
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_we;
   logic [1:0]        r_off;
   logic [2:0]        r_ctrl;
   logic              r_err, w_err_nxt;
   logic [31:0]       r_rdata, w_rdata_nxt;
   logic              r_mem_req, w_mem_req_nxt;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [31:0]       r_mem_wdata;
   logic              w_accept, w_issue;
   logic [1:0]        w_sel_off;
   logic [2:0]        w_sel_ctrl;
   logic [3:0]        w_be;
   logic [31:0]       w_store_word, w_load_data;
   logic              w_unused_addr;

   // In IDLE the aligner sees the live request; afterwards the latched one.
   assign w_sel_off  = (r_state == S_IDLE) ? cpu.cpu_addr[1:0] : r_off;
   assign w_sel_ctrl = (r_state == S_IDLE) ? cpu.cpu_dm_ctrl  : r_ctrl;
   assign w_unused_addr = ^cpu.cpu_addr[31:ADDR_W+2];

   dmem_lane_align u_align (
      .i_offset     (w_sel_off),
      .i_dm_ctrl    (w_sel_ctrl),
      .i_store_data (cpu.cpu_wdata),
      .i_load_word  (mem.mem_rdata),
      .o_be         (w_be),
      .o_store_word (w_store_word),
      .o_load_data  (w_load_data)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_err_nxt     = r_err;
      w_rdata_nxt   = r_rdata;
      w_mem_req_nxt = r_mem_req;
      w_accept      = 1'b0;
      w_issue       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cpu.cpu_req) begin
               w_accept  = 1'b1;
               w_cnt_nxt = '0;
               if (access_error(cpu.cpu_addr[1:0], cpu.cpu_dm_ctrl)) begin
                  w_state_nxt = S_RESP;
                  w_err_nxt   = 1'b1;
                  if (!cpu.cpu_we) w_rdata_nxt = '0;
               end else begin
                  w_issue       = 1'b1;
                  w_state_nxt   = S_WAIT;
                  w_err_nxt     = 1'b0;
                  w_mem_req_nxt = 1'b1;
               end
            end
         end
         S_WAIT: begin
            // Ack is checked first so it wins over a coincident timeout.
            if (mem.mem_ack) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = S_RESP;
               w_err_nxt     = 1'b0;
               if (!r_we) w_rdata_nxt = w_load_data;
            end else if (TIMEOUT != 0 && r_cnt == CNT_LAST) begin
               w_mem_req_nxt = 1'b0;
               w_state_nxt   = S_RESP;
               w_err_nxt     = 1'b1;
               if (!r_we) w_rdata_nxt = '0;
            end else if (TIMEOUT != 0) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_off       <= '0;
         r_ctrl      <= '0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_err     <= w_err_nxt;
         r_rdata   <= w_rdata_nxt;
         r_mem_req <= w_mem_req_nxt;
         if (w_accept) begin
            r_we   <= cpu.cpu_we;
            r_off  <= cpu.cpu_addr[1:0];
            r_ctrl <= cpu.cpu_dm_ctrl;
         end
         if (w_issue) begin
            r_mem_we    <= cpu.cpu_we;
            r_mem_addr  <= cpu.cpu_addr[ADDR_W+1:2];
            r_mem_be    <= cpu.cpu_we ? w_be : 4'b1111;
            r_mem_wdata <= cpu.cpu_we ? w_store_word : 32'h0;
         end
      end
   end

   assign cpu.cpu_ready = (r_state == S_RESP);
   assign cpu.cpu_err   = (r_state == S_RESP) & r_err;
   assign cpu.cpu_rdata = r_rdata;
   assign mem.mem_req   = r_mem_req;
   assign mem.mem_we    = r_mem_we;
   assign mem.mem_addr  = r_mem_addr;
   assign mem.mem_be    = r_mem_be;
   assign mem.mem_wdata = r_mem_wdata;

endmodule
